// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : shifter_pkg
// Description : Shared constants for the pipelined barrel shifter. Defines the
//               two-bit operation mode encoding used on the mode port and
//               carried down every pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

  localparam logic [1:0] MODE_ROT  = 2'b00;  // rotate
  localparam logic [1:0] MODE_LSH  = 2'b01;  // logical shift
  localparam logic [1:0] MODE_ASH  = 2'b10;  // arithmetic shift
  localparam logic [1:0] MODE_PASS = 2'b11;  // pass-through

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : One pipeline stage of the barrel shifter. Shifts or rotates
//               the incoming item by DIST bits when its amount bit is set,
//               then registers the result together with the item's control
//               fields for the next stage.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               i_en              - global advance enable (low = hold)
//               i_flush           - synchronous clear of the valid bit
//               i_valid/i_data/i_amount/i_lr/i_mode - item entering the stage
//               o_valid/o_data/o_amount/o_lr/o_mode - registered item
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DIST  = 1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_amount,
  input  logic             i_lr,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [SHW-1:0]   o_amount,
  output logic             o_lr,
  output logic [1:0]       o_mode
);

  // Amount bit that selects this stage's distance.
  localparam int K = $clog2(DIST);

  logic             w_fill;
  logic [WIDTH-1:0] w_rot_l;
  logic [WIDTH-1:0] w_rot_r;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shift;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_amount;
  logic             r_lr;
  logic [1:0]       r_mode;

  // Arithmetic right fills with the current MSB; an arithmetic right shift
  // never changes the MSB, so it still equals the original sign bit here.
  assign w_fill  = (i_mode == MODE_ASH) & i_data[WIDTH-1];
  assign w_rot_l = {i_data[WIDTH-DIST-1:0], i_data[WIDTH-1:WIDTH-DIST]};
  assign w_rot_r = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
  assign w_shl   = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
  assign w_shr   = {{DIST{w_fill}}, i_data[WIDTH-1:DIST]};

  always_comb begin
    w_shift = i_data;
    if (i_amount[K]) begin
      case (i_mode)
        MODE_ROT: w_shift = i_lr ? w_rot_l : w_rot_r;
        MODE_LSH,
        MODE_ASH: w_shift = i_lr ? w_shl : w_shr;
        default:  w_shift = i_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_amount <= '0;
      r_lr     <= 1'b0;
      r_mode   <= 2'b00;
    end else begin
      // Flush wins over the enable so it works even while stalled.
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_en) begin
        r_valid <= i_valid;
      end
      if (i_en) begin
        r_data   <= w_shift;
        r_amount <= i_amount;
        r_lr     <= i_lr;
        r_mode   <= i_mode;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_amount = r_amount;
  assign o_lr     = r_lr;
  assign o_mode   = r_mode;

endmodule
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : WIDTH-bit rotate / logical shift / arithmetic shift /
//               pass-through unit, pipelined with one stage per amount bit
//               (latency SHW, throughput one item per cycle). Valid/ready
//               handshake on both sides with a global stall and a
//               synchronous flush.
// Ports       : clk, rst_n         - clock, asynchronous active-low reset
//               flush              - clear all in-flight items next edge
//               in_valid, in_ready - input handshake
//               data_in, amount, lr, mode - operand and operation
//               out_valid, out_ready - output handshake
//               data_out           - result
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   amount,
  input  logic             lr,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
);

  // Index k is the input of stage k; index SHW is the last stage's output.
  logic             w_valid  [0:SHW];
  logic [WIDTH-1:0] w_data   [0:SHW];
  logic [SHW-1:0]   w_amount [0:SHW];
  logic             w_lr     [0:SHW];
  logic [1:0]       w_mode   [0:SHW];
  logic             w_en;
  logic [SHW+2:0]   w_unused_ctrl;

  // Global stall: everything advances unless a result is waiting unaccepted.
  // Depends only on registered state and out_ready, never on in_valid.
  assign w_en     = ~w_valid[SHW] | out_ready;
  assign in_ready = w_en;

  assign w_valid[0]  = in_valid;
  assign w_data[0]   = data_in;
  assign w_amount[0] = amount;
  assign w_lr[0]     = lr;
  assign w_mode[0]   = mode;

  generate
    for (genvar k = 0; k < SHW; k++) begin : g_stage
      shift_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << k)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_en),
        .i_flush  (flush),
        .i_valid  (w_valid[k]),
        .i_data   (w_data[k]),
        .i_amount (w_amount[k]),
        .i_lr     (w_lr[k]),
        .i_mode   (w_mode[k]),
        .o_valid  (w_valid[k+1]),
        .o_data   (w_data[k+1]),
        .o_amount (w_amount[k+1]),
        .o_lr     (w_lr[k+1]),
        .o_mode   (w_mode[k+1])
      );
    end
  endgenerate

  // Control fields leaving the last stage have no further consumer.
  assign w_unused_ctrl = {w_amount[SHW], w_lr[SHW], w_mode[SHW]};

  assign out_valid = w_valid[SHW];
  assign data_out  = w_data[SHW];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_barrel_shifter
// Description : Self-checking bench for pipelined_barrel_shifter (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   amount;
  logic             lr;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] a;
    logic       l;
    logic [1:0] m;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [15];
  vec_t sw   [64];
  vec_t st   [5];

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .amount    (amount),
    .lr        (lr),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // Behavioural reference: whole-word operators, not staged.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a,
                                       input logic l, input logic [1:0] m);
    logic [15:0] dd;
    logic [15:0] t;
    logic [7:0]  r;
    dd = {d, d};
    r  = d;
    case (m)
      2'b00: begin
        if (l) begin t = dd << a; r = t[15:8]; end
        else   begin t = dd >> a; r = t[7:0];  end
      end
      2'b01: r = l ? (d << a) : (d >> a);
      2'b10: r = l ? (d << a) : 8'($signed(d) >>> a);
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    data_in = v.d; amount = v.a; lr = v.l; mode = v.m;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (SHW + 2) tick();
  endtask

  // Single item: accept, then count cycles until it appears.
  task automatic run_one(input vec_t v, input string nm);
    int cnt;
    drive(v);
    in_valid = 1'b1;
    #1;
    chk({nm, " accept"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      tick();
      cnt++;
    end
    chk({nm, " latency"}, 32'(cnt), 32'd3);
    chk({nm, " data"}, 32'(data_out), 32'(v.exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    int recv;
    int stall_cnt;

    // Hand-computed directed vectors: {data, amount, lr, mode, expected}
    vecs[0]  = '{8'b10010010, 3'd3, 1'b1, 2'b00, 8'b10010100};
    vecs[1]  = '{8'b10010010, 3'd1, 1'b0, 2'b00, 8'b01001001};
    vecs[2]  = '{8'b10010010, 3'd2, 1'b0, 2'b01, 8'b00100100};
    vecs[3]  = '{8'b10010010, 3'd2, 1'b0, 2'b10, 8'b11100100};
    vecs[4]  = '{8'b10010010, 3'd4, 1'b1, 2'b01, 8'b00100000};
    vecs[5]  = '{8'b10010010, 3'd5, 1'b0, 2'b11, 8'b10010010};
    vecs[6]  = '{8'h81, 3'd1, 1'b1, 2'b00, 8'h03};
    vecs[7]  = '{8'h81, 3'd1, 1'b0, 2'b00, 8'hC0};
    vecs[8]  = '{8'h7F, 3'd3, 1'b0, 2'b10, 8'h0F};
    vecs[9]  = '{8'hF0, 3'd2, 1'b1, 2'b10, 8'hC0};
    vecs[10] = '{8'hA5, 3'd0, 1'b1, 2'b00, 8'hA5};
    vecs[11] = '{8'hA5, 3'd7, 1'b1, 2'b00, 8'hD2};
    vecs[12] = '{8'hA5, 3'd7, 1'b0, 2'b01, 8'h01};
    vecs[13] = '{8'hA5, 3'd7, 1'b1, 2'b01, 8'h80};
    vecs[14] = '{8'hA5, 3'd7, 1'b0, 2'b10, 8'hFF};

    for (int i = 0; i < 64; i++) begin
      sw[i].d   = 8'hB6 ^ 8'(i * 37);
      sw[i].a   = 3'(i % 8);
      sw[i].l   = 1'((i / 8) % 2);
      sw[i].m   = 2'(i / 16);
      sw[i].exp = model(sw[i].d, sw[i].a, sw[i].l, sw[i].m);
    end
    for (int i = 0; i < 5; i++) begin
      st[i].d   = 8'h1F + 8'(i * 45);
      st[i].a   = 3'(i + 1);
      st[i].l   = 1'(i % 2);
      st[i].m   = 2'(i % 3);
      st[i].exp = model(st[i].d, st[i].a, st[i].l, st[i].m);
    end

    // ---- Reset state ----
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    data_in = '0; amount = '0; lr = 1'b0; mode = 2'b00;
    #3;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset data_out", 32'(data_out), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    #9 rst_n = 1'b1;
    tick();

    // ---- Directed table ----
    for (int i = 0; i < 15; i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
    end
    drain();

    // ---- Back-to-back sweep, one item per cycle ----
    for (int c = 0; c < 70; c++) begin
      if (c < 64) begin
        drive(sw[c]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 2 && c <= 65) begin
        chk($sformatf("sweep%0d valid", c - 2), 32'(out_valid), 32'd1);
        chk($sformatf("sweep%0d data", c - 2), 32'(data_out), 32'(sw[c-2].exp));
      end else begin
        chk($sformatf("sweep cycle%0d idle", c + 1), 32'(out_valid), 32'd0);
      end
    end
    drain();

    // ---- Backpressure: stall 4 cycles after the second result ----
    sent = 0; recv = 0; stall_cnt = 0;
    for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
      out_ready = (stall_cnt == 0);
      in_valid  = (sent < 5);
      if (sent < 5) drive(st[sent]);
      #1;
      if (stall_cnt > 0) begin
        chk("stall in_ready", 32'(in_ready), 32'd0);
        chk("stall out_valid", 32'(out_valid), 32'd1);
        chk("stall data held", 32'(data_out), 32'(st[recv].exp));
        stall_cnt--;
      end else if (out_valid) begin
        chk($sformatf("stream%0d data", recv), 32'(data_out), 32'(st[recv].exp));
        recv++;
        if (recv == 2) stall_cnt = 4;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    chk("stream results delivered", 32'(recv), 32'd5);
    tick();
    chk("stream no duplicate", 32'(out_valid), 32'd0);
    drain();

    // ---- Flush with an item offered in the same cycle ----
    drive(vecs[0]); in_valid = 1'b1; tick();
    drive(vecs[3]); tick();
    drive(vecs[8]); flush = 1'b1;
    #1;
    chk("flush cycle in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int j = 0; j < SHW + 1; j++) begin
      chk($sformatf("post-flush idle%0d", j), 32'(out_valid), 32'd0);
      tick();
    end
    run_one(vecs[11], "after flush");
    drain();

    // ---- Asynchronous reset mid-cycle with items in flight ----
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(vecs[j]);
      tick();
    end
    drive(vecs[3]);
    chk("pre-reset out_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset data_out", 32'(data_out), 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("post-reset in_ready", 32'(in_ready), 32'd1);
    chk("post-reset out_valid", 32'(out_valid), 32'd0);
    run_one(vecs[14], "after reset");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational barrel rotator.
- Generalised to WIDTH bits, with four modes: rotate, logical shift, arithmetic shift and pass-through.
- One registered stage per shift-amount bit, with a valid/ready handshake, backpressure and synchronous flush.
- Sits in the datapath between an upstream producer and a downstream consumer that may stall.

Parameters:
WIDTH, 8, data width in bits; power of two, >= 2
SHW, $clog2(WIDTH), localparam; width of amount and number of pipeline stages

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all in-flight items
in_valid  input  1  input item present
in_ready  output  1  block can accept an item this cycle
data_in  input  WIDTH  operand
amount  input  SHW  shift/rotate distance, 0..WIDTH-1
lr  input  1  1 = left, 0 = right
mode  input  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 pass-through
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
data_out  output  WIDTH  result

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0, all stage data/control registers = 0; out_valid = 0, data_out = 0.
  - in_ready = 1 after reset.
- Global enable: en = ~out_valid | out_ready.
  - in_ready = en, combinational; no combinational path from in_valid to in_ready.
- Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
- Pipeline structure: stage k (k = 0..SHW-1) applies a shift of 2^k when the registered amount[k] = 1, otherwise passes data unchanged.
  - Each stage registers data, valid, lr, mode and the remaining amount bits.
  - Stage 0 consumes the raw inputs directly.
- Latency: exactly SHW cycles from accept to out_valid when not stalled (3 for WIDTH = 8).
  - Throughput: 1 item/cycle.
- Stall: when en = 0, every stage holds data and valid.
  - The pipeline never drops or duplicates items.
  - Bubbles are not compressed; stall is global.
- Mode rules:
  - Rotate: bits leaving one end re-enter at the other.
  - Logical shift: vacated bits = 0.
  - Arithmetic right: vacated bits = data_in[WIDTH-1], carried per stage as the current MSB, which is invariant under arithmetic right shift.
  - Arithmetic left: identical to logical left.
  - Pass-through: data unchanged regardless of amount/lr; still takes SHW cycles.
- amount = 0: output equals input in every mode.
- flush: at the next edge all valid bits clear, regardless of en.
  - An item presented in the same cycle as flush is discarded even if in_ready = 1.
  - Data registers need not clear.
- Reset mid-operation: all in-flight items are lost and out_valid drops immediately (asynchronous).
- data_out while out_valid = 0 is don't-care for checking; RTL holds the last stage contents.

Decomposition:
- Package shifter_pkg: mode constants MODE_ROT = 2'b00, MODE_LSH = 2'b01, MODE_ASH = 2'b10, MODE_PASS = 2'b11.
- Sub-module shift_stage, parameters WIDTH and DIST (= 2^k):
  - combinational shift/rotate/fill for one distance;
  - one register bank with enable, flush and async reset;
  - instantiated SHW times by generate.

Test Plan (WIDTH = 8, out_ready = 1 unless noted):
1. data_in = 8'b10010010, mode = 00, lr = 1, amount = 3 -> data_out = 8'b10010100 with out_valid exactly 3 cycles after accept; lr = 0, amount = 1 -> 8'b01001001.
2. Same data, lr = 0, amount = 2: mode 01 -> 8'b00100100; mode 10 -> 8'b11100100; mode 01, lr = 1, amount = 4 -> 8'b00100000; mode 11, amount = 5 -> 8'b10010010.
3. Sweep all 8 amounts × both lr × all modes back-to-back, one per cycle -> 64 results in order, one per cycle, each matching the reference model; first result at cycle 3.
4. Stream 5 items, drop out_ready for 4 cycles after the second result -> in_ready = 0 during the stall, out_valid and data_out held stable, all 5 results delivered in order with none lost or duplicated.
5. Three items in flight, assert flush for 1 cycle with in_valid = 1 -> out_valid stays 0 for the following SHW cycles; the next accepted item emerges normally.
6. Pull rst_n low asynchronously (mid-cycle) with items in flight -> out_valid = 0 and data_out = 0 immediately; after release, in_ready = 1 and the first new item returns after 3 cycles.
